// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// State encodings stay as plain localparams for legacy tool flows.
package bcd_pkg;
    localparam int NIB = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake plus held BCD digits between the
// requester (master) and the converter (slave).
interface bin2bcd_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [3:0]       BCD0;
    logic [3:0]       BCD1;
    logic [3:0]       BCD2;

    modport master (
        output start, bin,
        input  busy, done, BCD0, BCD1, BCD2
    );

    modport slave (
        input  start, bin,
        output busy, done, BCD0, BCD1, BCD2
    );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
// Inputs never exceed 9, so the 4-bit sum cannot overflow.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [NIB-1:0] in_nib,
    output logic [NIB-1:0] out_nib
);
    assign out_nib = (in_nib >= NIB'(5)) ? in_nib + NIB'(3) : in_nib;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH shifts,
// then the BCD nibbles are copied to held outputs with a one-cycle done.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    bin2bcd_seq_if.slave io
);
    localparam int BW = NIB * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          done_q, done_d;
    logic [BW-1:0] fix;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_nib  (sr_q[WIDTH + NIB*g +: NIB]),
            .out_nib (fix[NIB*g +: NIB])
        );
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    sr_d    = {{BW{1'b0}}, io.bin};
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Corrected digits and remaining binary shift as one word.
                sr_d  = SW'({fix, sr_q[WIDTH-1:0]} << 1);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = sr_q[SW-1 -: BW];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign io.busy = (state_q != S_IDLE);
    assign io.done = done_q;
    assign io.BCD0 = bcd_q[3:0];
    assign io.BCD1 = bcd_q[7:4];
    assign io.BCD2 = bcd_q[11:8];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected digits queued at issue,
// popped and compared by an independent monitor on every done pulse.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bin2bcd_seq_if #(.WIDTH(8)) io ();

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {io.BCD2, io.BCD1, io.BCD0};
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && io.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(outs()), 32'hFFFF_FFFF);
            end else begin
                chk("result", 32'(outs()), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!io.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!io.done) chk("done_timeout", 32'(n), 32'd0);
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] e);
        int lat;
        int bcnt;
        exp_q.push_back(e);
        @(negedge clk);
        io.start = 1'b1;
        io.bin   = v;
        @(negedge clk);
        io.start = 1'b0;
        io.bin   = 8'hA5;
        lat  = 0;
        bcnt = io.busy ? 1 : 0;
        while (!io.done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (io.busy) bcnt++;
        end
        chk("latency", 32'(lat), 32'd9);
        chk("busy_cycles", 32'(bcnt), 32'd9);
    endtask

    logic [7:0]  lv[7] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h17, 8'h2F, 8'h5E};
    logic [11:0] le[7] = '{12'h001, 12'h002, 12'h005, 12'h011, 12'h023, 12'h047, 12'h094};

    initial begin
        int n;
        io.start = 1'b0;
        io.bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_done", 32'(io.done), 32'd0);
        chk("rst_bcd", 32'(outs()), 32'h000);
        rst = 1'b0;

        convert(8'd127, 12'h127);
        convert(8'd0,   12'h000);
        convert(8'd255, 12'h255);
        convert(8'd99,  12'h099);

        // Second request while busy must be dropped.
        exp_q.push_back(12'h042);
        @(negedge clk);
        io.start = 1'b1;
        io.bin   = 8'd42;
        @(negedge clk);
        io.start = 1'b0;
        repeat (2) @(negedge clk);
        io.start = 1'b1;
        io.bin   = 8'd200;
        @(negedge clk);
        io.start = 1'b0;
        wait_done(n);
        repeat (15) @(negedge clk);
        chk("drop_busy", 32'(io.busy), 32'd0);
        chk("drop_hold", 32'(outs()), 32'h042);

        // Reset during SHIFT aborts with no done.
        @(negedge clk);
        io.start = 1'b1;
        io.bin   = 8'd200;
        @(negedge clk);
        io.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(io.busy), 32'd0);
        chk("abort_done", 32'(io.done), 32'd0);
        chk("abort_bcd", 32'(outs()), 32'h000);
        repeat (12) @(negedge clk);
        convert(8'd200, 12'h200);

        // Continuous start: back-to-back conversions every 10 cycles.
        @(negedge clk);
        io.bin   = lv[0];
        io.start = 1'b1;
        exp_q.push_back(le[0]);
        for (int i = 0; i < 7; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!io.done && n < 30);
            chk("period", 32'(n), 32'd10);
            if (i < 6) begin
                io.bin = lv[i+1];
                exp_q.push_back(le[i+1]);
            end else begin
                io.start = 1'b0;
            end
        end

        // Outputs hold while bin toggles without start.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            io.bin = 8'(i * 37 + 11);
        end
        chk("hold_bcd", 32'(outs()), 32'h094);
        repeat (12) @(negedge clk);
        chk("hold_bcd_late", 32'(outs()), 32'h094);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
